// File: rtl/hbmc_cmd_pkg.sv
// Shared definitions for the HyperBus command buffer: input FSM encoding and
// default widths used by hbmc_cmd_buf and its RAM.
package hbmc_cmd_pkg;

    localparam int C_DATA_WIDTH_DEF = 8;
    localparam int C_ADDR_WIDTH_DEF = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } in_state_e;

endpackage

// File: rtl/hbmc_cmd_buf_ram.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous read.
// Contents are not reset; the owner tracks validity with its pointers.
module hbmc_cmd_buf_ram
    import hbmc_cmd_pkg::*;
#(
    parameter int C_DATA_WIDTH = C_DATA_WIDTH_DEF,
    parameter int C_ADDR_WIDTH = C_ADDR_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [C_ADDR_WIDTH-1:0] waddr,
    input  logic [C_DATA_WIDTH-1:0] wdata,
    input  logic [C_ADDR_WIDTH-1:0] raddr,
    output logic [C_DATA_WIDTH-1:0] rdata
);

    logic [C_DATA_WIDTH-1:0] mem [0:(1 << C_ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read so the head word is visible right after its write edge.
    assign rdata = mem[raddr];

endmodule

// File: rtl/hbmc_cmd_buf.sv
// Command buffer: captures words from a 4-phase req/ack handshake into a FIFO
// and presents them as a valid/ready stream. HBMC_CMD_BUF_LEVEL_EN adds `level`.
module hbmc_cmd_buf
    import hbmc_cmd_pkg::*;
#(
    parameter int C_DATA_WIDTH = C_DATA_WIDTH_DEF,
    parameter int C_ADDR_WIDTH = C_ADDR_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic [C_DATA_WIDTH-1:0] in_data,
    input  logic                    in_req,
    output logic                    in_ack,
    output logic [C_DATA_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef HBMC_CMD_BUF_LEVEL_EN
    ,
    output logic [C_ADDR_WIDTH:0]   level
`endif
);

    localparam logic [C_ADDR_WIDTH:0] PTR_ONE = 1;

    in_state_e               state_q, state_d;
    logic                    in_ack_q, in_ack_d;
    logic [C_ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [C_ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                    empty;
    logic                    full;
    logic                    wr_en;
    logic                    rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[C_ADDR_WIDTH-1:0] == rd_ptr_q[C_ADDR_WIDTH-1:0])
                && (wr_ptr_q[C_ADDR_WIDTH] != rd_ptr_q[C_ADDR_WIDTH]);

    // Input FSM: state register
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= ST_IDLE;
            in_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_ack_q <= in_ack_d;
        end
    end

    // Input FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_req && !full) state_d = ST_ACK;
            ST_ACK:  if (!in_req)         state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // Input FSM: outputs. A held-high request only writes once because the
    // write is issued from ST_IDLE, which is left on the same edge.
    always_comb begin
        wr_en    = 1'b0;
        in_ack_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wr_en    = in_req && !full;
                in_ack_d = in_req && !full;
            end
            ST_ACK: begin
                in_ack_d = in_req;
            end
            default: begin
                wr_en    = 1'b0;
                in_ack_d = 1'b0;
            end
        endcase
    end

    assign in_ack = in_ack_q;

    // Full is judged on the pre-read pointers, so a same-cycle read never
    // lets a write through; the stalled request retries next cycle.
    assign rd_en = !empty && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign out_valid = !empty;

    hbmc_cmd_buf_ram #(
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .C_ADDR_WIDTH (C_ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q[C_ADDR_WIDTH-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr_q[C_ADDR_WIDTH-1:0]),
        .rdata (out_data)
    );

`ifdef HBMC_CMD_BUF_LEVEL_EN
    logic [C_ADDR_WIDTH:0] level_q, level_d;

    always_comb begin
        level_d = level_q;
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + PTR_ONE;
            2'b01:   level_d = level_q - PTR_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;
`endif

endmodule
